// File: rtl/commit_controller_pkg.sv
// Shared encodings for the retire stage: op codes of the ops it must recognise,
// op classes, sequencer states and store-size codes.
package commit_controller_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd3;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd4;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OPC_W-1:0] OP_LUI  = 5'd6;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'd16;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'd17;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'd18;
  localparam logic [OPC_W-1:0] OP_BGE  = 5'd19;
  localparam logic [OPC_W-1:0] OP_BLTU = 5'd20;
  localparam logic [OPC_W-1:0] OP_BGEU = 5'd21;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'd22;
  localparam logic [OPC_W-1:0] OP_JALR = 5'd23;
  localparam logic [OPC_W-1:0] OP_SB   = 5'd24;
  localparam logic [OPC_W-1:0] OP_SH   = 5'd25;
  localparam logic [OPC_W-1:0] OP_SW   = 5'd26;

  typedef enum logic [1:0] {
    CLS_OTHER  = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_JUMP   = 2'd2,
    CLS_STORE  = 2'd3
  } op_class_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] ST_SIZE_B = 2'd0;
  localparam logic [1:0] ST_SIZE_H = 2'd1;
  localparam logic [1:0] ST_SIZE_W = 2'd2;

endpackage

// File: rtl/commit_controller_classify.sv
// Pure combinational decode of the ROB head: op class, store size,
// mispredict detection and the architecturally correct next PC.
module commit_classify
  import commit_controller_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_pred,
  input  logic            i_outcome,
  input  logic [XLEN-1:0] i_pred_target,
  output op_class_t       o_class,
  output logic [1:0]      o_st_size,
  output logic            o_writes_rd,
  output logic            o_mispredict,
  output logic [XLEN-1:0] o_next_pc
);

  logic            w_tgt_miss;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_tgt_miss = (i_pred_target != i_addr);
  assign w_pc_plus4 = i_pc + XLEN'(4);

  always_comb begin
    o_class   = CLS_OTHER;
    o_st_size = ST_SIZE_W;
    case (i_op)
      OP_W'(OP_BEQ), OP_W'(OP_BNE), OP_W'(OP_BLT),
      OP_W'(OP_BGE), OP_W'(OP_BLTU), OP_W'(OP_BGEU): o_class = CLS_BRANCH;
      OP_W'(OP_JAL), OP_W'(OP_JALR):                 o_class = CLS_JUMP;
      OP_W'(OP_SB): begin
        o_class   = CLS_STORE;
        o_st_size = ST_SIZE_B;
      end
      OP_W'(OP_SH): begin
        o_class   = CLS_STORE;
        o_st_size = ST_SIZE_H;
      end
      OP_W'(OP_SW): begin
        o_class   = CLS_STORE;
        o_st_size = ST_SIZE_W;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_writes_rd  = 1'b0;
    o_mispredict = 1'b0;
    o_next_pc    = w_pc_plus4;
    case (o_class)
      CLS_OTHER: o_writes_rd = 1'b1;
      CLS_BRANCH: begin
        // A taken branch is also wrong when the BTB supplied a stale target.
        o_mispredict = (i_pred != i_outcome) || (i_outcome && w_tgt_miss);
        o_next_pc    = i_outcome ? i_addr : w_pc_plus4;
      end
      CLS_JUMP: begin
        o_writes_rd  = 1'b1;
        o_mispredict = w_tgt_miss;
        o_next_pc    = i_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/commit_controller.sv
// Retire-stage sequencer: retires, stalls on, or flushes at the ROB head and
// drives the RF write, the in-order store request and the fetch redirect.
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_ID_W = 3,
  parameter int OP_W     = 5,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                head_valid,
  input  logic [ROB_ID_W-1:0] head_id,
  input  logic [OP_W-1:0]     head_op,
  input  logic [4:0]          head_rd,
  input  logic [XLEN-1:0]     head_value,
  input  logic [XLEN-1:0]     head_pc,
  input  logic [XLEN-1:0]     head_addr,
  input  logic                head_pred,
  input  logic                head_outcome,
  input  logic [XLEN-1:0]     head_pred_target,
  output logic                commit_ack,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [ROB_ID_W-1:0] rf_rob_id,
  output logic                st_req,
  output logic [XLEN-1:0]     st_addr,
  output logic [XLEN-1:0]     st_data,
  output logic [1:0]          st_size,
  input  logic                st_done,
  output logic                flush,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [31:0]         retired_cnt
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_st_req;
  logic [XLEN-1:0] r_st_addr;
  logic [XLEN-1:0] r_st_data;
  logic [1:0]      r_st_size;
  logic            r_flush;
  logic [XLEN-1:0] r_redirect_pc;
  logic [31:0]     r_retired_cnt;

  op_class_t       w_class;
  logic [1:0]      w_st_size;
  logic            w_writes_rd;
  logic            w_mispredict;
  logic [XLEN-1:0] w_next_pc;
  logic            w_rd_write;
  logic            w_retire;
  logic            w_start_store;
  logic            w_store_done;
  logic            w_start_flush;

  commit_classify #(
    .OP_W (OP_W),
    .XLEN (XLEN)
  ) u_classify (
    .i_op          (head_op),
    .i_pc          (head_pc),
    .i_addr        (head_addr),
    .i_pred        (head_pred),
    .i_outcome     (head_outcome),
    .i_pred_target (head_pred_target),
    .o_class       (w_class),
    .o_st_size     (w_st_size),
    .o_writes_rd   (w_writes_rd),
    .o_mispredict  (w_mispredict),
    .o_next_pc     (w_next_pc)
  );

  assign w_rd_write = w_writes_rd && (head_rd != 5'd0);

  always_comb begin
    w_state_nxt   = r_state;
    commit_ack    = 1'b0;
    rf_we         = 1'b0;
    rf_waddr      = 5'd0;
    rf_wdata      = '0;
    rf_rob_id     = '0;
    w_retire      = 1'b0;
    w_start_store = 1'b0;
    w_store_done  = 1'b0;
    w_start_flush = 1'b0;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          if (head_valid) begin
            if (w_class == CLS_STORE) begin
              w_start_store = 1'b1;
              w_state_nxt   = S_ST_WAIT;
            end else begin
              // A mispredicted JAL/JALR still writes its link value now;
              // the head itself is retired during the flush cycle.
              rf_we     = w_rd_write;
              rf_waddr  = w_rd_write ? head_rd : 5'd0;
              rf_wdata  = w_rd_write ? head_value : '0;
              rf_rob_id = w_rd_write ? head_id : '0;
              if (w_mispredict) begin
                w_start_flush = 1'b1;
                w_state_nxt   = S_FLUSH;
              end else begin
                commit_ack = 1'b1;
                w_retire   = 1'b1;
              end
            end
          end
        end
        S_ST_WAIT: begin
          if (st_done) begin
            w_store_done = 1'b1;
            w_retire     = 1'b1;
            commit_ack   = head_valid;
            w_state_nxt  = S_RUN;
          end
        end
        S_FLUSH: begin
          w_retire    = 1'b1;
          w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_st_req      <= 1'b0;
      r_st_addr     <= '0;
      r_st_data     <= '0;
      r_st_size     <= 2'd0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_retired_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_start_flush;
      if (w_start_flush) r_redirect_pc <= w_next_pc;
      if (w_start_store) begin
        r_st_req  <= 1'b1;
        r_st_addr <= head_addr;
        r_st_data <= head_value;
        r_st_size <= w_st_size;
      end else if (w_store_done) begin
        r_st_req <= 1'b0;
      end
      if (w_retire) r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign st_req      = r_st_req;
  assign st_addr     = r_st_addr;
  assign st_data     = r_st_data;
  assign st_size     = r_st_size;
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_commit_controller.sv
// Self-checking bench for commit_controller: directed scenarios followed by
// random instruction streams checked against a per-instruction retire model.
module tb_commit_controller;
  import commit_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        head_valid;
  logic [2:0]  head_id;
  logic [4:0]  head_op;
  logic [4:0]  head_rd;
  logic [31:0] head_value;
  logic [31:0] head_pc;
  logic [31:0] head_addr;
  logic        head_pred;
  logic        head_outcome;
  logic [31:0] head_pred_target;
  logic        commit_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  rf_rob_id;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] retired_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 32'd0;

  always #5 clk = ~clk;

  commit_controller dut (
    .clk              (clk),
    .rst              (rst),
    .head_valid       (head_valid),
    .head_id          (head_id),
    .head_op          (head_op),
    .head_rd          (head_rd),
    .head_value       (head_value),
    .head_pc          (head_pc),
    .head_addr        (head_addr),
    .head_pred        (head_pred),
    .head_outcome     (head_outcome),
    .head_pred_target (head_pred_target),
    .commit_ack       (commit_ack),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .rf_rob_id        (rf_rob_id),
    .st_req           (st_req),
    .st_addr          (st_addr),
    .st_data          (st_data),
    .st_size          (st_size),
    .st_done          (st_done),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .retired_cnt      (retired_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // 0 other, 1 branch, 2 jump, 3 store
  function automatic int op_kind(input logic [4:0] op);
    if (op == OP_BEQ || op == OP_BNE || op == OP_BLT || op == OP_BGE ||
        op == OP_BLTU || op == OP_BGEU) return 1;
    if (op == OP_JAL || op == OP_JALR) return 2;
    if (op == OP_SB || op == OP_SH || op == OP_SW) return 3;
    return 0;
  endfunction

  task automatic run_instr(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] value,
                           input logic [31:0] pc, input logic [31:0] addr, input logic pred,
                           input logic outcome, input logic [31:0] ptgt, input logic [2:0] id,
                           input int st_delay);
    int          kind;
    bit          mis;
    bit          wr;
    logic [31:0] npc;
    logic [31:0] sz;
    kind = op_kind(op);
    mis  = (kind == 1) ? ((pred != outcome) || (outcome && ptgt != addr)) :
           (kind == 2) ? (ptgt != addr) : 1'b0;
    npc  = (kind == 2 || outcome) ? addr : pc + 32'd4;
    wr   = (kind == 0 || kind == 2) && (rd != 5'd0);
    sz   = (op == OP_SB) ? 32'd0 : (op == OP_SH) ? 32'd1 : 32'd2;
    head_valid = 1'b1; head_op = op; head_rd = rd; head_value = value; head_pc = pc;
    head_addr = addr; head_pred = pred; head_outcome = outcome; head_pred_target = ptgt;
    head_id = id;
    #2;
    if (kind == 3) begin
      check("st_detect_ack", 32'(commit_ack), 32'd0);
      check("st_detect_rfwe", 32'(rf_we), 32'd0);
      check("st_req_early", 32'(st_req), 32'd0);
      @(posedge clk); #1;
      check("st_req", 32'(st_req), 32'd1);
      check("st_addr", st_addr, addr);
      check("st_data", st_data, value);
      check("st_size", 32'(st_size), sz);
      check("st_wait_ack", 32'(commit_ack), 32'd0);
      for (int i = 1; i < st_delay; i++) begin
        @(posedge clk); #1;
        check("st_hold", 32'(st_req), 32'd1);
        check("st_hold_ack", 32'(commit_ack), 32'd0);
      end
      st_done = 1'b1;
      #1;
      check("st_done_ack", 32'(commit_ack), 32'd1);
      check("st_done_cnt", retired_cnt, exp_cnt);
      @(posedge clk); #1;
      st_done = 1'b0;
      exp_cnt = exp_cnt + 32'd1;
      check("st_req_drop", 32'(st_req), 32'd0);
      check("st_cnt", retired_cnt, exp_cnt);
    end else if (mis) begin
      check("mis_ack", 32'(commit_ack), 32'd0);
      check("mis_rfwe", 32'(rf_we), 32'(wr));
      if (wr) begin
        check("mis_waddr", 32'(rf_waddr), 32'(rd));
        check("mis_wdata", rf_wdata, value);
      end
      check("mis_flush_early", 32'(flush), 32'd0);
      @(posedge clk); #1;
      check("flush", 32'(flush), 32'd1);
      check("redirect_pc", redirect_pc, npc);
      check("flush_ack", 32'(commit_ack), 32'd0);
      check("flush_rfwe", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 32'd1;
      check("flush_drop", 32'(flush), 32'd0);
      check("flush_cnt", retired_cnt, exp_cnt);
    end else begin
      check("ret_ack", 32'(commit_ack), 32'd1);
      check("ret_rfwe", 32'(rf_we), 32'(wr));
      if (wr) begin
        check("ret_waddr", 32'(rf_waddr), 32'(rd));
        check("ret_wdata", rf_wdata, value);
        check("ret_robid", 32'(rf_rob_id), 32'(id));
      end
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 32'd1;
      check("ret_cnt", retired_cnt, exp_cnt);
    end
    head_valid = 1'b0;
  endtask

  task automatic idle_cycle(input bit pulse_done);
    head_valid = 1'b0;
    st_done    = pulse_done;
    #2;
    check("idle_ack", 32'(commit_ack), 32'd0);
    check("idle_rfwe", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    st_done = 1'b0;
    check("idle_streq", 32'(st_req), 32'd0);
    check("idle_flush", 32'(flush), 32'd0);
    check("idle_cnt", retired_cnt, exp_cnt);
  endtask

  logic [4:0] ops [15] = '{OP_ADD, OP_ADDI, OP_SUB, OP_XOR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
                           OP_BLTU, OP_BGEU, OP_JAL, OP_JALR, OP_SB, OP_SH, OP_SW};

  initial begin
    rst = 1'b1; head_valid = 1'b0; head_id = '0; head_op = '0; head_rd = '0;
    head_value = '0; head_pc = '0; head_addr = '0; head_pred = 1'b0; head_outcome = 1'b0;
    head_pred_target = '0; st_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(commit_ack), 32'd0);
    check("rst_rfwe", 32'(rf_we), 32'd0);
    check("rst_streq", 32'(st_req), 32'd0);
    check("rst_staddr", st_addr, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_instr(OP_ADD, 5'd5, 32'h1234, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 3'd2, 1);
    run_instr(OP_ADDI, 5'd0, 32'h55, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0, 3'd3, 1);
    run_instr(OP_BEQ, 5'd0, 32'h0, 32'h100, 32'h180, 1'b1, 1'b0, 32'h180, 3'd4, 1);
    run_instr(OP_JAL, 5'd1, 32'h108, 32'h104, 32'h240, 1'b1, 1'b1, 32'h200, 3'd5, 1);
    run_instr(OP_SW, 5'd0, 32'hAB, 32'h240, 32'h30000, 1'b0, 1'b0, 32'h0, 3'd6, 4);
    run_instr(OP_SB, 5'd0, 32'h1FF, 32'h244, 32'h30001, 1'b0, 1'b0, 32'h0, 3'd7, 1);
    run_instr(OP_BNE, 5'd0, 32'h0, 32'h248, 32'h400, 1'b1, 1'b1, 32'h400, 3'd0, 1);
    run_instr(OP_BLT, 5'd0, 32'h0, 32'h400, 32'h500, 1'b1, 1'b1, 32'h504, 3'd1, 1);
    idle_cycle(1'b1);

    // reset while a store waits for the memory unit
    head_valid = 1'b1; head_op = OP_SW; head_addr = 32'h44; head_value = 32'h9;
    @(posedge clk); #1;
    check("rstw_streq", 32'(st_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstw_streq_drop", 32'(st_req), 32'd0);
    check("rstw_cnt", retired_cnt, 32'd0);
    exp_cnt = 32'd0;
    rst = 1'b0; head_valid = 1'b0;
    idle_cycle(1'b0);

    // reset during the flush pulse
    head_valid = 1'b1; head_op = OP_BGE; head_pc = 32'h10; head_pred = 1'b0;
    head_outcome = 1'b1; head_addr = 32'h90; head_pred_target = 32'h90;
    @(posedge clk); #1;
    check("rstf_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstf_flush_drop", 32'(flush), 32'd0);
    rst = 1'b0; head_valid = 1'b0;
    idle_cycle(1'b0);

    for (int n = 0; n < 120; n++) begin
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] ptgt;
      op   = ops[$urandom_range(0, 14)];
      addr = $urandom & 32'hFFFF_FFFC;
      ptgt = ($urandom_range(0, 1) == 0) ? addr : ($urandom & 32'hFFFF_FFFC);
      run_instr(op, 5'($urandom_range(0, 31)), $urandom, $urandom & 32'hFFFF_FFFC, addr,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ptgt,
                3'($urandom_range(0, 7)), int'($urandom_range(1, 5)));
      if ($urandom_range(0, 4) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
